// File: rtl/divsqrt_if.sv
// Request/response bundle between a Goldschmidt divide/sqrt controller and its user.
// The master drives the request fields; the slave is the controller.
interface divsqrt_if;
    logic               start;
    logic [63:0]        Float1;
    logic [63:0]        Float2b;
    logic               op_type;
    logic               P;
    logic               ready;
    logic               load;
    logic               iter_en;
    logic [2:0]         iter_cnt;
    logic               round_en;
    logic signed [12:0] exp_pre;
    logic               exp_odd;
    logic               sign_q;
    logic               P_q;
    logic               special;
    logic [63:0]        special_res;
    logic               invalid;
    logic               divzero;
    logic               done;

    modport master (
        output start, Float1, Float2b, op_type, P,
        input  ready, load, iter_en, iter_cnt, round_en, exp_pre, exp_odd,
               sign_q, P_q, special, special_res, invalid, divzero, done
    );

    modport slave (
        input  start, Float1, Float2b, op_type, P,
        output ready, load, iter_en, iter_cnt, round_en, exp_pre, exp_odd,
               sign_q, P_q, special, special_res, invalid, divzero, done
    );
endinterface

// File: rtl/divsqrt_ctrl.sv
// Sequencing controller for a Goldschmidt divide/sqrt datapath: operand capture,
// IEEE special-case screening, exponent/sign precompute and iteration pacing.
module divsqrt_ctrl #(
    parameter int ITER = 4,
    parameter int CPI  = 2
) (
    input  logic      clk,
    input  logic      reset,
    divsqrt_if.slave  bus
);
    localparam logic [63:0] QNAN = 64'h7FF8_0000_0000_0000;

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_ITER, S_ROUND, S_DONE} state_t;

    state_t      state_q, state_d;
    logic [7:0]  cyc_q, cyc_d;
    logic [2:0]  iter_q, iter_d;
    logic        valid_q, valid_d;
    logic [63:0] a_q, a_d, b_q, b_d;
    logic        op_q, op_d, prec_q, prec_d;

    logic [10:0]        e1, e2;
    logic               zero1, zero2, inf1, inf2, nan1, nan2;
    logic               sp_c, inv_c, dz_c, sign_c, odd_c;
    logic [63:0]        res_c;
    logic signed [12:0] e1s, e2s, ub, exp_c;

    // Classification and result precompute from the captured operands.
    always_comb begin
        e1     = a_q[62:52];
        e2     = b_q[62:52];
        zero1  = (e1 == 11'd0);
        zero2  = (e2 == 11'd0);
        inf1   = (e1 == 11'h7FF) && (a_q[51:0] == 52'd0);
        inf2   = (e2 == 11'h7FF) && (b_q[51:0] == 52'd0);
        nan1   = (e1 == 11'h7FF) && (a_q[51:0] != 52'd0);
        nan2   = (e2 == 11'h7FF) && (b_q[51:0] != 52'd0);
        e1s    = signed'({2'b00, e1});
        e2s    = signed'({2'b00, e2});
        ub     = e1s - 13'sd1023;
        sp_c   = 1'b0;
        inv_c  = 1'b0;
        dz_c   = 1'b0;
        res_c  = 64'd0;
        odd_c  = 1'b0;
        if (!op_q) begin
            sign_c = a_q[63] ^ b_q[63];
            exp_c  = e1s - e2s + 13'sd1023;
            sp_c   = nan1 | nan2 | inf1 | inf2 | zero1 | zero2;
            if (nan1 || nan2) begin
                res_c = QNAN;
            end else if ((inf1 && inf2) || (zero1 && zero2)) begin
                res_c = QNAN;
                inv_c = 1'b1;
            end else if (zero2 && !inf1) begin
                res_c = {sign_c, 11'h7FF, 52'd0};
                dz_c  = 1'b1;
            end else if (inf1) begin
                res_c = {sign_c, 11'h7FF, 52'd0};
            end else if (zero1 || inf2) begin
                res_c = {sign_c, 63'd0};
            end
        end else begin
            sign_c = a_q[63];
            exp_c  = (ub >>> 1) + 13'sd1023;
            odd_c  = ub[0];
            sp_c   = nan1 | zero1 | inf1 | a_q[63];
            if (nan1) begin
                res_c = QNAN;
            end else if (a_q[63] && !zero1) begin
                res_c = QNAN;
                inv_c = 1'b1;
            end else if (zero1) begin
                res_c = {sign_c, 63'd0};
            end else if (inf1) begin
                res_c = {1'b0, 11'h7FF, 52'd0};
            end
        end
    end

    // Result fields read zero until the first operation has been captured.
    assign bus.special     = valid_q & sp_c;
    assign bus.special_res = valid_q ? res_c : 64'd0;
    assign bus.invalid     = valid_q & inv_c;
    assign bus.divzero     = valid_q & dz_c;
    assign bus.sign_q      = valid_q & sign_c;
    assign bus.exp_pre     = valid_q ? exp_c : 13'sd0;
    assign bus.exp_odd     = valid_q & odd_c;
    assign bus.P_q         = valid_q & prec_q;
    assign bus.iter_cnt    = iter_q;

    always_comb begin
        state_d      = state_q;
        cyc_d        = cyc_q;
        iter_d       = iter_q;
        valid_d      = valid_q;
        a_d          = a_q;
        b_d          = b_q;
        op_d         = op_q;
        prec_d       = prec_q;
        bus.ready    = 1'b0;
        bus.load     = 1'b0;
        bus.iter_en  = 1'b0;
        bus.round_en = 1'b0;
        bus.done     = 1'b0;
        case (state_q)
            S_IDLE: begin
                bus.ready = 1'b1;
                if (bus.start) begin
                    a_d     = bus.Float1;
                    b_d     = bus.Float2b;
                    op_d    = bus.op_type;
                    prec_d  = bus.P;
                    valid_d = 1'b1;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                bus.load = 1'b1;
                cyc_d    = 8'd0;
                iter_d   = 3'd0;
                state_d  = sp_c ? S_DONE : S_ITER;
            end
            S_ITER: begin
                bus.iter_en = 1'b1;
                if (cyc_q == 8'(CPI - 1)) begin
                    cyc_d = 8'd0;
                    if (iter_q == 3'(ITER - 1)) begin
                        iter_d  = 3'd0;
                        state_d = S_ROUND;
                    end else begin
                        iter_d = iter_q + 3'd1;
                    end
                end else begin
                    cyc_d = cyc_q + 8'd1;
                end
            end
            S_ROUND: begin
                bus.round_en = 1'b1;
                state_d      = S_DONE;
            end
            S_DONE: begin
                bus.done = 1'b1;
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cyc_q   <= 8'd0;
            iter_q  <= 3'd0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cyc_q   <= cyc_d;
            iter_q  <= iter_d;
            valid_q <= valid_d;
        end
    end

    // Operand registers carry no reset; valid_q masks them until first capture.
    always_ff @(posedge clk) begin
        a_q    <= a_d;
        b_q    <= b_d;
        op_q   <= op_d;
        prec_q <= prec_d;
    end
endmodule

// File: doc/divsqrt_ctrl.md
DIVSQRT_CTRL -- requirements
Module: divsqrt_ctrl

Interface
REQ-001: Parameter ITER, default 4; number of Goldschmidt iterations.
REQ-002: Parameter CPI, default 2; cycles per iteration (datapath multiplier latency).
REQ-003: clk  in  1  sole clock; all state updates on rising edge.
REQ-004: reset  in  1  synchronous, active-high.
REQ-005: start  in  1  request strobe; accepted only when start & ready.
REQ-006: Float1  in  64  converted operand A, IEEE double layout (single-precision operands arrive pre-widened, low 29 bits zero).
REQ-007: Float2b  in  64  converted operand B (equals Float1 for sqrt).
REQ-008: op_type  in  1  0 = divide, 1 = sqrt.
REQ-009: P  in  1  result precision, 0 double, 1 single.
REQ-010: ready  out  1  high only in IDLE.
REQ-011: load  out  1  one-cycle pulse; datapath captures mantissas.
REQ-012: iter_en  out  1  high during every ITER-state cycle.
REQ-013: iter_cnt  out  3  current iteration index, 0..ITER-1.
REQ-014: round_en  out  1  high in ROUND state.
REQ-015: exp_pre  out  13  signed preliminary biased result exponent.
REQ-016: exp_odd  out  1  sqrt unbiased exponent was odd (datapath pre-shifts mantissa).
REQ-017: sign_q  out  1  result sign.
REQ-018: P_q  out  1  registered P.
REQ-019: special  out  1  result is special, taken from special_res, not datapath.
REQ-020: special_res  out  64  special result value, double layout.
REQ-021: invalid  out  1  IEEE invalid-operation flag.
REQ-022: divzero  out  1  IEEE divide-by-zero flag.
REQ-023: done  out  1  one-cycle pulse; all result outputs valid in that cycle.

Function
REQ-024: FSM states IDLE, LOAD, ITER, ROUND, DONE.
REQ-025: IDLE: on start, register Float1, Float2b, op_type, P; go to LOAD; start otherwise ignored.
REQ-026: LOAD: load=1; classify registered operands; special -> DONE, else -> ITER.
REQ-027: ITER: lasts exactly ITER*CPI cycles; iter_cnt increments after every CPI cycles; then -> ROUND.
REQ-028: ROUND: one cycle -> DONE; DONE: one cycle, done=1 -> IDLE.
REQ-029: Latency from accepting cycle (cycle 0): normal done at cycle ITER*CPI+3 (11 with defaults); special done at cycle 2.
REQ-030: start in any non-IDLE state, including DONE, is ignored; no queuing.
REQ-031: Classification: exponent 0 is zero (denormals flushed, sign kept); exponent 0x7FF with fraction 0 is Inf; exponent 0x7FF with fraction nonzero is NaN.
REQ-032: Divide: sign_q = s1 ^ s2; exp_pre = e1 - e2 + 1023, 13-bit signed, no saturation.
REQ-033: Sqrt: sign_q = s1; exp_pre = ((e1 - 1023) >>> 1) + 1023, arithmetic shift; exp_odd = (e1 - 1023) bit 0.
REQ-034: Divide specials, priority order: NaN operand -> qNaN; Inf/Inf or 0/0 -> qNaN, invalid; finite nonzero/0 -> signed Inf, divzero; Inf/x -> signed Inf; 0/x or x/Inf -> signed zero.
REQ-035: Sqrt specials, priority order: NaN -> qNaN; negative nonzero (including -Inf) -> qNaN, invalid; +-0 -> +-0; +Inf -> +Inf.
REQ-036: qNaN = 0x7FF8000000000000; Inf = {sign, 0x7FF, 52'b0}; zero = {sign, 63'b0}.
REQ-037: special, special_res, invalid, divzero, exp_pre, exp_odd, sign_q, P_q hold from LOAD until next accepted start.
REQ-038: When special=0, invalid=0 and divzero=0.

Reset
REQ-039: reset forces IDLE from any state, including mid-ITER; a start in the reset cycle is ignored.
REQ-040: Cycle after reset: ready=1; load, iter_en, round_en, done, special, invalid, divzero, sign_q, exp_odd, P_q = 0; iter_cnt=0; exp_pre=0; special_res=0.

Verification
REQ-041: div 0x4018000000000000 / 0x4000000000000000 -> done at cycle 11, exp_pre=1024, sign_q=0, special=0, iter_en high cycles 2-9, iter_cnt 0,0,1,1,2,2,3,3.
REQ-042: div 0x3FF0000000000000 / 0 -> done at cycle 2, special_res=0x7FF0000000000000, divzero=1, invalid=0, iter_en never high.
REQ-043: sqrt 0xC010000000000000 -> done at cycle 2, special_res=0x7FF8000000000000, invalid=1.
REQ-044: sqrt 0x4030000000000000 (16.0) -> exp_pre=1025, exp_odd=0; sqrt 0x4020000000000000 (8.0) -> exp_pre=1024, exp_odd=1.
REQ-045: reset in 5th ITER cycle together with start -> next cycle ready=1, done=0, outputs at reset values; following start completes normally.
REQ-046: start held high continuously -> one operation per 12 cycles (accept, 10 busy, DONE, re-accept in IDLE), done never in consecutive cycles.
